// File: rtl/sipo_deser.sv
`timescale 1ns/1ps
`default_nettype none
// sipo_deser: serial-in/parallel-out deserializer with a single-entry valid/ready
// holding buffer and sticky overrun / partial-frame error flags.
module sipo_deser #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 bit_i,
  input  logic                 bit_valid_i,
  input  logic                 sof_i,
  output logic [W-1:0]         word_o,
  output logic                 word_valid_o,
  input  logic                 word_ready_i,
  output logic [$clog2(W)-1:0] bit_cnt_o,
  output logic                 overrun_o,
  output logic                 frame_err_o,
  input  logic                 clear_i
);

  localparam int            c_cw   = $clog2(W);
  localparam logic [c_cw-1:0] c_last = c_cw'(W - 1);

  logic [W-1:0]    r_shift;
  logic [W-1:0]    r_word;
  logic [c_cw-1:0] r_cnt;
  logic            r_valid;
  logic            r_ovr;
  logic            r_ferr;

  logic [W-1:0]    w_shift_nxt;
  logic [c_cw-1:0] w_cnt_base;
  logic [c_cw-1:0] w_pos;
  logic            w_sof;
  logic            w_last;
  logic            w_consume;
  logic            w_load;
  logic            w_ovr_set;
  logic            w_ferr_set;

  always_comb begin
    w_sof       = bit_valid_i && sof_i;
    // A start-of-frame restarts the word, so the incoming bit is always the first one.
    w_cnt_base  = w_sof ? '0 : r_cnt;
    w_pos       = MSB_FIRST ? (c_last - w_cnt_base) : w_cnt_base;
    w_shift_nxt = r_shift;
    w_shift_nxt[w_pos] = bit_i;
    w_last      = bit_valid_i && (w_cnt_base == c_last);
    w_consume   = r_valid && word_ready_i;
    w_load      = w_last && (!r_valid || word_ready_i);
    w_ovr_set   = w_last && r_valid && !word_ready_i;
    w_ferr_set  = w_sof && (r_cnt != '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      if (bit_valid_i) begin
        r_shift <= w_shift_nxt;
        r_cnt   <= w_last ? '0 : (w_cnt_base + c_cw'(1));
      end
      if (w_load) begin
        r_word  <= w_shift_nxt;
        r_valid <= 1'b1;
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end
      // A new error event takes priority over a coincident clear.
      r_ovr  <= w_ovr_set  | (r_ovr  & ~clear_i);
      r_ferr <= w_ferr_set | (r_ferr & ~clear_i);
    end
  end

  assign word_o       = r_word;
  assign word_valid_o = r_valid;
  assign bit_cnt_o    = r_cnt;
  assign overrun_o    = r_ovr;
  assign frame_err_o  = r_ferr;

endmodule
`default_nettype wire
